// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: exponentiation sequencer states,
// MontMul operand-select codes and the default operand width.
package rsa_pkg;

    localparam int DEF_WIDTH = 1024;

    typedef enum logic [3:0] {
        IDLE,
        LOOP,
        SQR_GO,
        SQR_WAIT,
        MUL_GO,
        MUL_WAIT,
        FIN_GO,
        FIN_WAIT,
        DONE
    } exp_state_t;

    // Source of the core's B operand; A is always the accumulator.
    typedef enum logic [1:0] {
        SEL_ACC,
        SEL_XT,
        SEL_ONE
    } opsel_t;

endpackage

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one Montgomery multiplier;
// converts the final accumulator out of the Montgomery domain with MontMul(A, 1).
module mont_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int EXP_WIDTH = 32,
    parameter int LEN_W     = 6
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x_tilde,
    input  logic [WIDTH-1:0]     r_mod_n,
    input  logic [WIDTH-1:0]     modulus,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [LEN_W-1:0]     exp_len,
    input  logic                 abort,
    output logic                 mont_start,
    output logic [WIDTH-1:0]     mont_a,
    output logic [WIDTH-1:0]     mont_b,
    output logic [WIDTH-1:0]     mont_m,
    input  logic [WIDTH-1:0]     mont_result,
    input  logic                 mont_done,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result
);

    localparam logic [LEN_W-1:0] EXP_MAX = LEN_W'(EXP_WIDTH);

    exp_state_t           state;
    opsel_t               b_sel;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     xt_r;
    logic [WIDTH-1:0]     mod_r;
    logic [EXP_WIDTH-1:0] exp_r;
    logic [LEN_W-1:0]     idx;
    logic [LEN_W-1:0]     len_clamped;
    logic                 accept;
    logic                 exp_bit;

    assign accept      = (state == IDLE) && start && !abort;
    assign len_clamped = (exp_len > EXP_MAX) ? EXP_MAX : exp_len;
    // Mask-and-reduce keeps the select width-independent of LEN_W.
    assign exp_bit     = |(exp_r & (EXP_WIDTH'(1) << idx));

    // Operand registers are only meaningful while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            xt_r  <= x_tilde;
            mod_r <= modulus;
            exp_r <= exponent;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            b_sel      <= SEL_ACC;
            acc        <= '0;
            idx        <= '0;
            mont_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
        end else begin
            mont_start <= 1'b0;
            done       <= 1'b0;
            if (abort && (state != IDLE)) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            acc   <= r_mod_n;
                            idx   <= len_clamped;
                            busy  <= 1'b1;
                            state <= LOOP;
                        end
                    end
                    LOOP: begin
                        mont_start <= 1'b1;
                        if (idx == '0) begin
                            b_sel <= SEL_ONE;
                            state <= FIN_GO;
                        end else begin
                            idx   <= idx - 1'b1;
                            b_sel <= SEL_ACC;
                            state <= SQR_GO;
                        end
                    end
                    SQR_GO: state <= SQR_WAIT;
                    SQR_WAIT: begin
                        if (mont_done) begin
                            acc <= mont_result;
                            if (exp_bit) begin
                                mont_start <= 1'b1;
                                b_sel      <= SEL_XT;
                                state      <= MUL_GO;
                            end else begin
                                state <= LOOP;
                            end
                        end
                    end
                    MUL_GO: state <= MUL_WAIT;
                    MUL_WAIT: begin
                        if (mont_done) begin
                            acc   <= mont_result;
                            state <= LOOP;
                        end
                    end
                    FIN_GO: state <= FIN_WAIT;
                    FIN_WAIT: begin
                        if (mont_done) begin
                            result <= mont_result;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // acc and b_sel only change on the edge that consumes mont_done, so the
    // operands stay stable for the whole time the core is working.
    assign mont_a = acc;
    assign mont_m = busy ? mod_r : '0;

    always_comb begin
        mont_b = acc;
        case (b_sel)
            SEL_XT:  mont_b = xt_r;
            SEL_ONE: mont_b = WIDTH'(1);
            default: mont_b = acc;
        endcase
    end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl with a behavioural 10-cycle Montgomery core (R = 2^16).
module tb_mont_exp_ctrl;

    localparam int W  = 16;
    localparam int EW = 32;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [W-1:0]  x_tilde;
    logic [W-1:0]  r_mod_n;
    logic [W-1:0]  modulus;
    logic [EW-1:0] exponent;
    logic [LW-1:0] exp_len;
    logic          abort;
    logic          mont_start;
    logic [W-1:0]  mont_a;
    logic [W-1:0]  mont_b;
    logic [W-1:0]  mont_m;
    logic [W-1:0]  mont_result;
    logic          mont_done;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;

    int checks = 0;
    int errors = 0;

    mont_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW), .LEN_W(LW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .x_tilde(x_tilde),
        .r_mod_n(r_mod_n), .modulus(modulus), .exponent(exponent),
        .exp_len(exp_len), .abort(abort), .mont_start(mont_start),
        .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
        .mont_result(mont_result), .mont_done(mont_done), .busy(busy),
        .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] montmul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] n);
        logic [W+1:0] t;
        t = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, n};
            t = t >> 1;
        end
        if (t >= {2'b00, n}) t = t - {2'b00, n};
        return t[W-1:0];
    endfunction

    // Behavioural core: fixed latency, logs every operand pair it is given.
    logic         core_run;
    int           core_cnt;
    logic [W-1:0] core_a, core_b, core_n;
    logic [W-1:0] log_a[$];
    logic [W-1:0] log_b[$];
    int           overlap_cnt = 0;
    int           idle_start_cnt = 0;
    int           unstable_cnt = 0;
    int           done_cnt = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            core_run    <= 1'b0;
            core_cnt    <= 0;
            mont_done   <= 1'b0;
            mont_result <= '0;
        end else begin
            mont_done <= 1'b0;
            if (mont_start) begin
                if (core_run) overlap_cnt <= overlap_cnt + 1;
                if (!busy) idle_start_cnt <= idle_start_cnt + 1;
                core_run <= 1'b1;
                core_cnt <= 10;
                core_a   <= mont_a;
                core_b   <= mont_b;
                core_n   <= mont_m;
                log_a.push_back(mont_a);
                log_b.push_back(mont_b);
            end else if (core_run) begin
                if (busy && (mont_a !== core_a || mont_b !== core_b))
                    unstable_cnt <= unstable_cnt + 1;
                if (core_cnt == 1) begin
                    core_run    <= 1'b0;
                    mont_done   <= 1'b1;
                    mont_result <= montmul(core_a, core_b, core_n);
                end
                core_cnt <= core_cnt - 1;
            end
        end
    end

    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic launch(input logic [W-1:0] xt, input logic [W-1:0] rm, input logic [W-1:0] n,
                          input logic [EW-1:0] e, input logic [LW-1:0] len);
        @(posedge clk); #1;
        x_tilde = xt; r_mod_n = rm; modulus = n; exponent = e; exp_len = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit seen;
        bit low_busy;
        seen = 1'b0;
        low_busy = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) low_busy = 1'b1;
            if (done === 1'b1) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_busy_held"}, 64'(low_busy), 64'd0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check({tag, "_busy_cleared"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int base;
        int d0;
        bit hit;
        logic [W-1:0] exp_a [6];
        logic [W-1:0] exp_b [6];
        exp_a = '{16'd132, 16'd132, 16'd69, 16'd148, 16'd154, 16'd179};
        exp_b = '{16'd132, 16'd69, 16'd69, 16'd148, 16'd69, 16'd1};

        resetn = 1'b0; start = 1'b0; abort = 1'b0;
        x_tilde = '0; r_mod_n = '0; modulus = '0; exponent = '0; exp_len = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mont_start", 64'(mont_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_acc", 64'(mont_a), 64'd0);
        resetn = 1'b1;

        // N=197, R mod N = 132, X=5 -> x_tilde = 69; e = 0b101 -> 5^5 mod 197 = 170
        base = log_a.size();
        d0 = done_cnt;
        launch(16'd69, 16'd132, 16'd197, 32'b101, 6'd3);
        wait_done(500, "e101");
        check("e101_result", 64'(result), 64'd170);
        check("e101_ops", 64'(log_a.size() - base), 64'd6);
        check("e101_done_pulses", 64'(done_cnt - d0), 64'd1);
        if (log_a.size() >= base + 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("e101_op%0d_a", i), 64'(log_a[base+i]), 64'(exp_a[i]));
                check($sformatf("e101_op%0d_b", i), 64'(log_b[base+i]), 64'(exp_b[i]));
            end
        end

        // e=3, len=2 -> 125; start latency, mont_m, and an ignored start while busy
        base = log_a.size();
        launch(16'd69, 16'd132, 16'd197, 32'd3, 6'd2);
        check("lat_no_start_cycle1", 64'(mont_start), 64'd0);
        @(posedge clk); #1;
        check("lat_start_cycle2", 64'(mont_start), 64'd1);
        check("mont_m_busy", 64'(mont_m), 64'd197);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; exp_len = 6'd0; exponent = 32'hFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(500, "e3");
        check("e3_result", 64'(result), 64'd125);
        check("e3_ops", 64'(log_a.size() - base), 64'd5);

        // exp_len = 0: single MontMul(R mod N, 1)
        base = log_a.size();
        launch(16'd69, 16'd132, 16'd197, 32'hFFFF_FFFF, 6'd0);
        wait_done(200, "len0");
        check("len0_result", 64'(result), 64'd1);
        check("len0_ops", 64'(log_a.size() - base), 64'd1);
        if (log_a.size() >= base + 1) begin
            check("len0_a", 64'(log_a[base]), 64'd132);
            check("len0_b", 64'(log_b[base]), 64'd1);
        end

        // exp_len = 40 clamps to 32: 32 squarings + 1 multiply + final
        base = log_a.size();
        launch(16'd69, 16'd132, 16'd197, 32'h1, 6'd40);
        wait_done(2000, "clamp");
        check("clamp_result", 64'(result), 64'd5);
        check("clamp_ops", 64'(log_a.size() - base), 64'd34);

        // abort during the third squaring (ops S,M,S,M,S for e=0b111)
        base = log_a.size();
        d0 = done_cnt;
        launch(16'd69, 16'd132, 16'd197, 32'b111, 6'd3);
        hit = 1'b0;
        for (int k = 0; k < 300 && !hit; k++) begin
            @(negedge clk);
            if (log_a.size() >= base + 5) hit = 1'b1;
        end
        check("abort_reach_sqr3", 64'(hit), 64'd1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_mont_start", 64'(mont_start), 64'd0);
        repeat (30) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_result_kept", 64'(result), 64'd5);
        check("abort_no_more_ops", 64'(log_a.size() - base), 64'd5);
        check("abort_late_done_ignored", 64'(busy), 64'd0);

        base = log_a.size();
        launch(16'd69, 16'd132, 16'd197, 32'd3, 6'd2);
        wait_done(500, "post_abort");
        check("post_abort_result", 64'(result), 64'd125);
        check("post_abort_ops", 64'(log_a.size() - base), 64'd5);

        // abort and start together in IDLE: start is dropped
        base = log_a.size();
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        check("abort_start_no_ops", 64'(log_a.size() - base), 64'd0);

        check("no_overlapping_starts", 64'(overlap_cnt), 64'd0);
        check("no_idle_starts", 64'(idle_start_cnt), 64'd0);
        check("operands_stable", 64'(unstable_cnt), 64'd0);

        // asynchronous reset while a mont_start pulse is up
        base = log_a.size();
        launch(16'd69, 16'd132, 16'd197, 32'b101, 6'd3);
        hit = 1'b0;
        for (int k = 0; k < 300 && !hit; k++) begin
            @(negedge clk);
            if (log_a.size() >= base + 2 && mont_start === 1'b1) hit = 1'b1;
        end
        check("rst_mid_reach", 64'(hit), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_mid_mont_start", 64'(mont_start), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_result", 64'(result), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
